// File: rtl/conv_pkg.sv
// Shared types for the dilated conv stack: sequencer states and the
// layer-select width helper used by the sequencer and MAC datapath.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    START,
    WAIT,
    OUT
  } seq_state_t;

  function automatic int layer_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_watchdog.sv
// Cycle counter guarding the shared MAC; flags a lost mac_done once
// the MAC has been waited on for MAC_TIMEOUT cycles.
module mac_watchdog #(
  parameter int MAC_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(MAC_TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign expired = enable &&
    (cnt_q == CW'(MAC_TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/conv_stack_sequencer.sv
// Per-sample layer walker: shifts each layer cache, runs the shared
// MAC on it, and flags the final-layer result as network output.
module conv_stack_sequencer
  import conv_pkg::*;
#(
  parameter int NUM_LAYERS  = 4,
  parameter int MAC_TIMEOUT = 64,
  localparam int LAYER_W    = layer_w(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic [LAYER_W-1:0]    layer_sel,
  output logic [NUM_LAYERS-1:0] cache_shift,
  output logic                  mac_start,
  input  logic                  mac_done,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  err_timeout,
  input  logic                  clear_err
);

  localparam logic [LAYER_W-1:0] LAST =
    LAYER_W'(NUM_LAYERS - 1);

  seq_state_t         state_q;
  seq_state_t         state_d;
  logic [LAYER_W-1:0] layer_q;
  logic [LAYER_W-1:0] layer_d;
  logic               err_q;
  logic               err_d;
  logic               wd_expired;

  mac_watchdog #(
    .MAC_TIMEOUT(MAC_TIMEOUT)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == START),
    .enable (state_q == WAIT),
    .expired(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    err_d   = err_q;
    if (clear_err) begin
      err_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        layer_d = '0;
        if (sample_valid) begin
          state_d = SHIFT;
        end
      end
      SHIFT: state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        // A done on the expiry cycle still counts as a good result.
        if (mac_done) begin
          if (layer_q == LAST) begin
            state_d = OUT;
          end else begin
            layer_d = layer_q + LAYER_W'(1);
            state_d = SHIFT;
          end
        end else if (wd_expired) begin
          err_d   = 1'b1;
          layer_d = '0;
          state_d = IDLE;
        end
      end
      OUT: begin
        layer_d = '0;
        state_d = IDLE;
      end
      default: begin
        layer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      layer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    cache_shift = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      cache_shift[i] = (state_q == SHIFT) &&
        (layer_q == LAYER_W'(i));
    end
  end

  assign sample_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign mac_start    = (state_q == START);
  assign out_valid    = (state_q == OUT);
  assign layer_sel    = layer_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_conv_stack_sequencer.sv
// Directed bench: 3 layers, MAC done 2 cycles after start, timeout 8.
module tb_conv_stack_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_valid;
  logic       sample_ready;
  logic [1:0] layer_sel;
  logic [2:0] cache_shift;
  logic       mac_start;
  logic       mac_done;
  logic       out_valid;
  logic       busy;
  logic       err_timeout;
  logic       clear_err;

  int nchk = 0;
  int nerr = 0;
  int pend = 0;
  bit mac_auto = 1'b0;
  int bad;

  always #5 clk = ~clk;

  conv_stack_sequencer #(
    .NUM_LAYERS (3),
    .MAC_TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .layer_sel   (layer_sel),
    .cache_shift (cache_shift),
    .mac_start   (mac_start),
    .mac_done    (mac_done),
    .out_valid   (out_valid),
    .busy        (busy),
    .err_timeout (err_timeout),
    .clear_err   (clear_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // MAC model: done asserted in the 2nd cycle after a start pulse
  task automatic tick();
    @(posedge clk);
    #1;
    if (mac_auto) mac_done = (pend == 1);
    if (mac_start) pend = 2;
    else if (pend > 0) pend--;
  endtask

  task automatic finish_sample(input string tag, input int n);
    int nb;
    nb = 0;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i < n && out_valid) nb++;
    end
    chk({tag, "_out"}, out_valid, 1);
    chk({tag, "_early_out"}, nb, 0);
  endtask

  initial begin
    rst = 1'b1;
    sample_valid = 1'b0;
    mac_done = 1'b0;
    clear_err = 1'b0;
    tick();
    tick();
    chk("rst_ready", sample_ready, 1);
    chk("rst_shift", cache_shift, 0);
    chk("rst_start", mac_start, 0);
    chk("rst_out", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lsel", layer_sel, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;
    tick();

    // normal timing with sample_valid held for back-to-back accept
    mac_auto = 1'b1;
    sample_valid = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      chk("t1_shift", cache_shift,
          c == 1 ? 1 : c == 5 ? 2 : c == 9 ? 4 : 0);
      chk("t1_start", mac_start,
          32'(c == 2 || c == 6 || c == 10));
      chk("t1_out", out_valid, 32'(c == 13));
      chk("t1_ready", sample_ready, 32'(c == 14));
      chk("t1_lsel", layer_sel,
          c < 5 ? 0 : c < 9 ? 1 : c < 14 ? 2 : 0);
    end
    tick();
    sample_valid = 1'b0;
    chk("t2_shift", cache_shift, 1);
    chk("t2_busy", busy, 1);
    finish_sample("t2", 12);
    tick();
    chk("t2_idle", sample_ready, 1);

    // MAC never answers: timeout after 8 WAIT cycles
    mac_auto = 1'b0;
    mac_done = 1'b0;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    bad = 0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (out_valid) bad++;
    end
    chk("t3_err_pre", err_timeout, 0);
    chk("t3_busy_pre", busy, 1);
    tick();
    if (out_valid) bad++;
    chk("t3_err", err_timeout, 1);
    chk("t3_busy", busy, 0);
    chk("t3_lsel", layer_sel, 0);
    chk("t3_no_out", bad, 0);
    mac_auto = 1'b1;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    finish_sample("t3_next", 12);
    chk("t3_err_sticky", err_timeout, 1);
    tick();

    // stray done in IDLE/SHIFT/START is ignored
    mac_auto = 1'b0;
    mac_done = 1'b1;
    tick();
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_out", out_valid, 0);
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    chk("t4_shift", cache_shift, 1);
    chk("t4_shift_lsel", layer_sel, 0);
    tick();
    chk("t4_start", mac_start, 1);
    chk("t4_start_lsel", layer_sel, 0);
    tick();
    mac_done = 1'b0;
    chk("t4_wait_busy", busy, 1);
    chk("t4_wait_shift", cache_shift, 0);
    chk("t4_wait_lsel", layer_sel, 0);
    tick();
    chk("t4_wait2_shift", cache_shift, 0);
    chk("t4_wait2_out", out_valid, 0);
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    chk("t4_l1_shift", cache_shift, 2);
    chk("t4_l1_lsel", layer_sel, 1);
    tick();
    tick();
    chk("t5_wait_lsel", layer_sel, 1);

    // reset in WAIT of layer 1
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_lsel", layer_sel, 0);
    chk("t5_shift", cache_shift, 0);
    chk("t5_start", mac_start, 0);
    chk("t5_out", out_valid, 0);
    chk("t5_err", err_timeout, 0);

    // clear_err coincident with timeout: set wins
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t6_setwins_err", err_timeout, 1);
    chk("t6_setwins_busy", busy, 0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("t6_clear", err_timeout, 0);

    // done on the expiry cycle: layer advances, no error
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    mac_done = 1'b1;
    tick();
    mac_done = 1'b0;
    mac_auto = 1'b1;
    chk("t6_adv_shift", cache_shift, 2);
    chk("t6_adv_lsel", layer_sel, 1);
    chk("t6_adv_err", err_timeout, 0);
    finish_sample("t6_adv", 8);
    chk("t6_adv_err_end", err_timeout, 0);
    tick();
    chk("t6_idle", sample_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule
